// File: rtl/ps2_keypress_rx.sv
// PS/2 keyboard receiver: deserializes device-to-host frames and emits make codes only.
// Define PS2_PARITY_CHECK_EN to drop frames that fail the odd-parity check.
module ps2_keypress_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   clk_s, data_s, fall, timeout;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic [TW-1:0]          to_cnt;
    logic                   break_pending, ext_pending;
    logic                   byte_ok, err;
    logic                   parity_ok;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // A falling edge in the same cycle wins over the timeout, since it clears the counter.
    assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first, otherwise unassigned paths infer a latch.
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_s) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_ok = 1'b0;
        err     = 1'b0;
        if (timeout) begin
            err = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE:    err = data_s;
                STOP:    if (data_s && parity_ok) byte_ok = 1'b1;
                         else                     err     = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge clock) begin
        if (reset)                          par_bit <= 1'b0;
        else if (fall && state == PARITY)   par_bit <= data_s;
    end

    assign parity_ok = ^{shift, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt       <= 3'd0;
            shift         <= 8'h00;
            to_cnt        <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            scan_code     <= 8'h00;
            code_valid    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= err;

            if (fall)               to_cnt <= '0;
            else if (state != IDLE) to_cnt <= to_cnt + TW'(1);
            else                    to_cnt <= '0;

            if (fall && state == IDLE) bit_cnt <= 3'd0;
            if (fall && state == DATA) begin
                shift   <= {data_s, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            // Prefix bytes only arm the flags; the byte that follows them is swallowed.
            if (byte_ok) begin
                if (shift == 8'hF0) begin
                    break_pending <= 1'b1;
                end else if (shift == 8'hE0) begin
                    ext_pending <= 1'b1;
                end else if (break_pending || ext_pending) begin
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end else begin
                    scan_code  <= shift;
                    code_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ps2_keypress_rx.md
Name: ps2_keypress_rx

Overview:
- Receives the raw PS/2 keyboard serial stream and deserializes 11-bit device-to-host frames.
- Strips break (release) and extended-prefix sequences.
- Emits one 8-bit make scan code per key press, with a one-cycle valid strobe.
- Sits directly upstream of the scan-code-to-seven-segment decoder and the Enigma keypress path.

Parameters:
- TIMEOUT_CYCLES, 50000, system clocks allowed between PS/2 clock falling edges mid-frame before the frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on ps2_clk and ps2_data (minimum 2).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous, idles high.
- ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous, idles high.
- scan_code  output  8  last accepted make code; held until the next accepted code.
- code_valid  output  1  one-cycle pulse when scan_code is updated.
- frame_err  output  1  one-cycle pulse on an aborted or malformed frame.

Behaviour:
- Reset is synchronous and active-high, on the single clock.
- Reset values:
  - scan_code = 8'h00, code_valid = 0, frame_err = 0.
  - Synchronizer flops = 1.
  - FSM = IDLE, bit counter = 0, timeout counter = 0.
  - break_pending = 0, ext_pending = 0.
- Reset asserted mid-frame discards the partial frame and both pending flags.
- Input conditioning:
  - SYNC_STAGES-deep synchronizer on each input.
  - Falling edge = previous synchronized clock 1, current 0.
  - Data is sampled only in the cycle the falling edge is detected.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- FSM, advancing only on falling edges:
  - IDLE: data = 0 -> DATA, clear bit counter. Data = 1 -> stay in IDLE, frame_err pulse (bad start).
  - DATA: shift data into the MSB of an 8-bit shift register (right shift). After 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: data = 1 and parity OK -> byte accepted. Otherwise frame_err pulse. Always -> IDLE.
- Timeout counter:
  - Cleared on every falling edge; increments each cycle while FSM != IDLE.
  - Reaching TIMEOUT_CYCLES -> FSM = IDLE, frame_err pulse, partial byte discarded, pending flags unchanged.
- Byte decode, applied to each accepted byte:
  - 8'hF0 -> break_pending = 1, no output.
  - 8'hE0 -> ext_pending = 1, no output.
  - Any other byte with break_pending or ext_pending set -> clear both, no output.
  - Any other byte with neither set -> scan_code = byte, code_valid = 1.
- Consequences of the decode rules:
  - Releases (F0 xx) are suppressed.
  - Extended keys (E0 xx, E0 F0 xx) are suppressed.
  - Typematic repeats of a held key produce repeated code_valid pulses.
- Latency: code_valid and frame_err go high in the cycle immediately after the cycle in which the stop-bit falling edge (or timeout) is detected, for exactly one cycle.
- code_valid and frame_err are never high in the same cycle.
- No backpressure: the consumer must take the code on the pulse.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: odd parity is checked. XOR of 8 data bits and the parity bit must equal 1; otherwise the STOP state gives a frame_err pulse and the byte is dropped.
- Undefined: the parity bit is captured and ignored. Only start, stop and timeout errors produce frame_err.

Test Plan:
- Bench PS/2 clock period is at least 16 system cycles. Data changes on the PS/2 clock high phase.
- Frame 8'h1C, parity 0 -> scan_code = 8'h1C, a single-cycle code_valid pulse, frame_err stays 0.
- Frames F0, 1C -> no code_valid; scan_code keeps its prior value. Then frame 32 -> code_valid, scan_code = 8'h32.
- Frames E0 75, then E0 F0 75, then 24 -> exactly one code_valid, scan_code = 8'h24.
- Frame 1C with parity bit 1:
  - With PS2_PARITY_CHECK_EN -> frame_err pulse, no code_valid.
  - Without the macro -> code_valid, scan_code = 8'h1C.
- Start plus 4 data bits, then idle for TIMEOUT_CYCLES+10 -> frame_err pulse, FSM back to IDLE. Next full frame 2B -> scan_code = 8'h2B.
- Sequence with a mid-frame reset:
  - Frame F0, then reset mid-frame after 5 bits, then frame 1C -> code_valid, scan_code = 8'h1C (pending flag cleared by reset).
  - All outputs are 0 in the cycle after reset is applied.
